iter_muldiv: RTL and testbench
==============================

Name: iter_muldiv

Overview:
Parametrised iterative multiply/divide unit for the EX stage. It replaces separate fixed 32-bit mul/div blocks with one shared datapath. The unit takes a start/annul handshake and signed or unsigned operands, and produces a 2*WIDTH-bit {hi,lo} result after a fixed iteration count. EX holds its stall request while busy_o is high and writes the HI/LO registers on ready_o.

Parameters:
WIDTH, 32, operand width in bits (legal: 8..64, even).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived localparam; not overridable).

Ports:
clk  in  1  rising-edge clock.
resetn  in  1  synchronous reset, active-low.
start_i  in  1  request new operation; sampled only in IDLE.
mode_i  in  1  0 = multiply, 1 = divide.
signed_i  in  1  1 = two's-complement operands.
opdata1_i  in  WIDTH  multiplicand / dividend.
opdata2_i  in  WIDTH  multiplier / divisor.
annul_i  in  1  abort current operation (flush).
busy_o  out  1  high in CALC and DONE.
ready_o  out  1  one-cycle pulse; result_o valid.
result_o  out  2*WIDTH  mul: full product {hi,lo}; div: {remainder, quotient}.
div_zero_o  out  1  divide-by-zero flag; same timing as result_o.

Behaviour:
- Reset: synchronous on the clk edge while resetn=0. Effects: state to IDLE; busy_o=0, ready_o=0, result_o=0, div_zero_o=0; counter and internal registers cleared. Reset mid-operation abandons the operation with no ready_o.
- States: IDLE, CALC, DONE.
- IDLE -> CALC when start_i=1 and annul_i=0. At acceptance:
  - latch mode and sign flags;
  - latch |opdata1_i| and |opdata2_i| when signed_i=1, raw operands otherwise;
  - record sign_a and sign_b;
  - clear the counter.
- IDLE + start_i + annul_i: annul wins; stay in IDLE.
- Divide by zero (mode_i=1, opdata2_i=0) at acceptance: go IDLE -> DONE directly. Quotient = all-ones, remainder = opdata1_i (unmodified, sign ignored), div_zero_o=1.
- CALC runs exactly WIDTH iterations, one per cycle; the counter counts 0..WIDTH-1.
  - Multiply: shift-add. Accumulator is 2*WIDTH bits; each cycle add the multiplicand if the multiplier LSB is 1, then shift.
  - Divide: restoring. Partial remainder is WIDTH+1 bits; shift in the next dividend bit; subtract the divisor; keep the difference if it is non-negative and set the quotient bit.
- CALC -> DONE on the cycle after the last iteration.
- In DONE: apply sign correction, register result_o and div_zero_o, assert ready_o for exactly that one cycle, then go DONE -> IDLE unconditionally.
- Sign correction:
  - mul: negate the 2*WIDTH-bit product if sign_a ^ sign_b.
  - div: negate the quotient if sign_a ^ sign_b; negate the remainder if sign_a. Remainder takes the dividend's sign (truncating division).
- Signed overflow (most-negative / -1): quotient = most-negative value (wraps), remainder = 0, div_zero_o=0.
- Latency: acceptance at edge N gives ready_o high in cycle N+WIDTH+1. The divide-by-zero path gives ready_o in cycle N+1.
- result_o and div_zero_o hold their value until the next ready_o; they are unchanged by annul or by a new start.
- start_i while busy_o=1 is ignored; it is not queued.
- annul_i=1 in CALC: go to IDLE next cycle, no ready_o, result_o unchanged.
- annul_i=1 in DONE: ready_o is suppressed in that cycle; go to IDLE.
- Operand inputs are not required to be stable after acceptance.

Decomposition:
- Shared header constants:
  - MODE_MUL/MODE_DIV;
  - state encodings IDLE/CALC/DONE;
  - MdStart/MdStop and MdResultReady/NotReady.
- One combinational sub-module, iter_muldiv_signfix, is natural: WIDTH-parametrised conditional two's-complement negation. It is instantiated for operand abs and for result correction.
- FSM, counter and datapath stay in iter_muldiv.

Test Plan:
1. WIDTH=32, mul signed, -3 × 5 -> ready_o at cycle 33 after acceptance; result_o=64'hFFFFFFFF_FFFFFFF1; div_zero_o=0.
2. Div signed, -7 / 2 -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD} (r=-1, q=-3). Div unsigned, 100 / 7 -> {32'd2, 32'd14}.
3. Div by zero, 0x1234 / 0 -> ready_o one cycle after acceptance; result_o={32'h00001234, 32'hFFFFFFFF}; div_zero_o=1.
4. Signed overflow, 0x80000000 / 0xFFFFFFFF -> {32'h0, 32'h80000000}, div_zero_o=0. Unsigned 0xFFFFFFFF × 0xFFFFFFFF -> 64'hFFFFFFFE_00000001.
5. annul_i at iteration 10 of a divide -> no ready_o, IDLE next cycle, result_o keeps the previous value. A new start then completes normally. start_i pulsed during CALC is ignored.
6. Reset and parameter sweep:
   - resetn=0 mid-CALC -> all outputs 0 next cycle.
   - WIDTH=8: signed -128 × -1 = 16'h0080; unsigned 200 / 3 = {8'd2, 8'd66}; ready_o at cycle 9.

Source files
------------

// File: rtl/iter_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation modes,
// FSM state encodings and handshake levels.
package iter_muldiv_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  localparam logic MdStart = 1'b1;
  localparam logic MdStop  = 1'b0;

  localparam logic MdResultReady    = 1'b1;
  localparam logic MdResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/response bundle between EX and the multiply/divide unit.
// The master drives operands and start/annul; the slave returns status and the result.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               mode_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;
  logic               div_zero_o;

  modport master (
    output start_i, mode_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  busy_o, ready_o, result_o, div_zero_o
  );

  modport slave (
    input  start_i, mode_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output busy_o, ready_o, result_o, div_zero_o
  );
endinterface

// File: rtl/iter_muldiv_signfix.sv
// Conditional two's-complement negation, used both to take operand magnitudes
// and to restore the sign of the result. Purely combinational.
module iter_muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~a + W'(1)) : a;
endmodule

// File: rtl/iter_muldiv.sv
// Shared iterative multiplier (shift-add) / divider (restoring) on unsigned magnitudes.
// ready_o pulses WIDTH+1 cycles after acceptance (1 cycle for divide-by-zero); start_i is ignored while busy.
module iter_muldiv
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         resetn,
  iter_muldiv_if.slave md
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_t          state;
  logic               mode_q;
  logic               sign_a;
  logic               sign_b;
  logic               dz_q;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] fixed_result;

  iter_muldiv_signfix #(.W(WIDTH)) u_abs_a (
    .a(md.opdata1_i), .neg(md.signed_i & md.opdata1_i[WIDTH-1]), .y(abs_a));
  iter_muldiv_signfix #(.W(WIDTH)) u_abs_b (
    .a(md.opdata2_i), .neg(md.signed_i & md.opdata2_i[WIDTH-1]), .y(abs_b));
  iter_muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .a(acc), .neg(sign_a ^ sign_b), .y(prod_fix));
  iter_muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .a(acc[WIDTH-1:0]), .neg(sign_a ^ sign_b), .y(quo_fix));
  iter_muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .a(rem), .neg(sign_a), .y(rem_fix));

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide: acc[WIDTH-1:0] shifts dividend bits out the top and quotient bits in the bottom.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  // Divide-by-zero bypasses sign correction: raw dividend and all-ones quotient.
  assign fixed_result = (mode_q == MODE_MUL) ? prod_fix :
                        dz_q                 ? {rem, acc[WIDTH-1:0]} :
                                               {rem_fix, quo_fix};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      mode_q        <= MODE_MUL;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      dz_q          <= 1'b0;
      opa           <= '0;
      opb           <= '0;
      acc           <= '0;
      rem           <= '0;
      cnt           <= '0;
      md.busy_o     <= 1'b0;
      md.ready_o    <= MdResultNotReady;
      md.result_o   <= '0;
      md.div_zero_o <= 1'b0;
    end else begin
      md.ready_o <= MdResultNotReady;
      case (state)
        IDLE: begin
          if (md.start_i == MdStart && !md.annul_i) begin
            mode_q    <= md.mode_i;
            sign_a    <= md.signed_i & md.opdata1_i[WIDTH-1];
            sign_b    <= md.signed_i & md.opdata2_i[WIDTH-1];
            opa       <= abs_a;
            opb       <= abs_b;
            cnt       <= '0;
            md.busy_o <= 1'b1;
            if (md.mode_i == MODE_DIV && md.opdata2_i == '0) begin
              dz_q  <= 1'b1;
              rem   <= md.opdata1_i;
              acc   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              state <= DONE;
            end else begin
              dz_q  <= 1'b0;
              rem   <= '0;
              acc   <= {{WIDTH{1'b0}}, (md.mode_i == MODE_MUL) ? abs_b : abs_a};
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (md.annul_i) begin
            state     <= IDLE;
            md.busy_o <= 1'b0;
          end else begin
            if (mode_q == MODE_MUL) begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end else begin
              rem              <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
              acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= DONE;
          end
        end
        DONE: begin
          state     <= IDLE;
          md.busy_o <= 1'b0;
          if (!md.annul_i) begin
            md.ready_o    <= MdResultReady;
            md.result_o   <= fixed_result;
            md.div_zero_o <= dz_q;
          end
        end
        default: begin
          state     <= IDLE;
          md.busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iter_muldiv.sv
// Scoreboard bench for iter_muldiv at WIDTH=32 and WIDTH=8: drivers queue expected
// results and ready cycles, negedge monitors pop and compare on every ready_o.
module tb_iter_muldiv;
  import iter_muldiv_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  iter_muldiv_if #(.WIDTH(32)) b32 ();
  iter_muldiv_if #(.WIDTH(8))  b8 ();

  iter_muldiv #(.WIDTH(32)) u32 (.clk(clk), .resetn(resetn), .md(b32.slave));
  iter_muldiv #(.WIDTH(8))  u8  (.clk(clk), .resetn(resetn), .md(b8.slave));

  typedef struct {
    string       nm;
    logic [63:0] res;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (b32.ready_o === 1'b1) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL spurious_ready32: got result %h dz %b at cycle %0d, expected no ready", b32.result_o, b32.div_zero_o, cyc);
      end else begin
        e = q32.pop_front();
        if (b32.result_o !== e.res || b32.div_zero_o !== e.dz || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: got result %h dz %b cycle %0d, expected %h dz %b cycle %0d",
                   e.nm, b32.result_o, b32.div_zero_o, cyc, e.res, e.dz, e.cyc);
        end
      end
    end
    if (b8.ready_o === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL spurious_ready8: got result %h at cycle %0d, expected no ready", b8.result_o, cyc);
      end else begin
        e = q8.pop_front();
        if ({48'h0, b8.result_o} !== e.res || b8.div_zero_o !== e.dz || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: got result %h dz %b cycle %0d, expected %h dz %b cycle %0d",
                   e.nm, b8.result_o, b8.div_zero_o, cyc, e.res[15:0], e.dz, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after acceptance.
  task automatic issue32(input string nm, input logic mode, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input logic dz);
    exp_t e;
    b32.start_i = 1'b1; b32.mode_i = mode; b32.signed_i = sgn;
    b32.opdata1_i = a; b32.opdata2_i = b;
    e.nm = nm; e.res = res; e.dz = dz; e.cyc = cyc + 1 + (dz ? 1 : 33);
    q32.push_back(e);
    @(negedge clk);
    b32.start_i = 1'b0; b32.mode_i = ~mode; b32.signed_i = ~sgn;
    b32.opdata1_i = $urandom; b32.opdata2_i = $urandom;
  endtask

  task automatic issue8(input string nm, input logic mode, input logic sgn,
                        input logic [7:0] a, input logic [7:0] b, input logic [15:0] res);
    exp_t e;
    b8.start_i = 1'b1; b8.mode_i = mode; b8.signed_i = sgn;
    b8.opdata1_i = a; b8.opdata2_i = b;
    e.nm = nm; e.res = {48'h0, res}; e.dz = 1'b0; e.cyc = cyc + 1 + 9;
    q8.push_back(e);
    @(negedge clk);
    b8.start_i = 1'b0; b8.mode_i = ~mode; b8.signed_i = ~sgn;
    b8.opdata1_i = 8'($urandom); b8.opdata2_i = 8'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    if (q32.size() != 0 || q8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d+%0d results outstanding, expected 0", q32.size(), q8.size());
      q32.delete();
      q8.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b32.start_i = 1'b0; b32.mode_i = MODE_MUL; b32.signed_i = 1'b0;
    b32.opdata1_i = '0; b32.opdata2_i = '0; b32.annul_i = 1'b0;
    b8.start_i = 1'b0; b8.mode_i = MODE_MUL; b8.signed_i = 1'b0;
    b8.opdata1_i = '0; b8.opdata2_i = '0; b8.annul_i = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {61'h0, b32.busy_o, b32.ready_o, b32.div_zero_o}, 64'h0);
    chk("reset_result", b32.result_o, 64'h0);
    resetn = 1'b1;
    @(negedge clk);

    issue32("mul_s_m3x5", MODE_MUL, 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
    chk("busy_in_calc", {63'h0, b32.busy_o}, 64'h1);
    drain();
    issue32("div_s_m7d2", MODE_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    drain();
    issue32("div_s_7dm2", MODE_DIV, 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
    drain();
    issue32("div_u_100d7", MODE_DIV, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    drain();
    issue32("mul_s_m4xm6", MODE_MUL, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFA, 64'd24, 1'b0);
    drain();
    issue32("div_zero", MODE_DIV, 1'b0, 32'h00001234, 32'd0, 64'h00001234_FFFFFFFF, 1'b1);
    drain();
    issue32("div_zero_s_neg", MODE_DIV, 1'b1, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 1'b1);
    drain();
    issue32("mul_u_max", MODE_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
    drain();
    issue32("div_s_ovf", MODE_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    drain();

    // Annul while in DONE (divide-by-zero goes straight there).
    b32.start_i = 1'b1; b32.mode_i = MODE_DIV; b32.signed_i = 1'b0;
    b32.opdata1_i = 32'd5; b32.opdata2_i = 32'd0;
    @(negedge clk);
    b32.start_i = 1'b0; b32.annul_i = 1'b1;
    @(negedge clk);
    b32.annul_i = 1'b0;
    chk("annul_done_busy", {63'h0, b32.busy_o}, 64'h0);
    chk("annul_done_result", {b32.result_o[62:0], b32.div_zero_o}, {63'h80000000, 1'b0} << 0);
    repeat (3) @(negedge clk);

    // Annul at iteration 10 of a divide.
    b32.start_i = 1'b1; b32.mode_i = MODE_DIV; b32.signed_i = 1'b0;
    b32.opdata1_i = 32'd1000; b32.opdata2_i = 32'd3;
    @(negedge clk);
    b32.start_i = 1'b0;
    repeat (10) @(negedge clk);
    b32.annul_i = 1'b1;
    @(negedge clk);
    b32.annul_i = 1'b0;
    chk("annul_calc_busy", {63'h0, b32.busy_o}, 64'h0);
    chk("annul_calc_result", b32.result_o, 64'h00000000_80000000);
    repeat (40) @(negedge clk);

    // Start together with annul in IDLE is dropped.
    b32.start_i = 1'b1; b32.annul_i = 1'b1; b32.mode_i = MODE_MUL;
    @(negedge clk);
    b32.start_i = 1'b0; b32.annul_i = 1'b0;
    chk("idle_annul_busy", {63'h0, b32.busy_o}, 64'h0);
    repeat (40) @(negedge clk);

    // Restart after annul; a start pulse during CALC must be ignored.
    issue32("mul_u_after_annul", MODE_MUL, 1'b0, 32'h10, 32'h20, 64'h200, 1'b0);
    repeat (5) @(negedge clk);
    b32.start_i = 1'b1; b32.mode_i = MODE_DIV; b32.opdata1_i = 32'd9; b32.opdata2_i = 32'd0;
    @(negedge clk);
    b32.start_i = 1'b0;
    chk("busy_ignores_start", {63'h0, b32.busy_o}, 64'h1);
    drain();

    // Reset in the middle of CALC.
    b32.start_i = 1'b1; b32.mode_i = MODE_MUL; b32.signed_i = 1'b0;
    b32.opdata1_i = 32'd7; b32.opdata2_i = 32'd9;
    @(negedge clk);
    b32.start_i = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midcalc_reset_flags", {61'h0, b32.busy_o, b32.ready_o, b32.div_zero_o}, 64'h0);
    chk("midcalc_reset_result", b32.result_o, 64'h0);
    repeat (40) @(negedge clk);

    issue8("w8_mul_s_m128xm1", MODE_MUL, 1'b1, 8'h80, 8'hFF, 16'h0080);
    drain();
    issue8("w8_div_u_200d3", MODE_DIV, 1'b0, 8'd200, 8'd3, {8'd2, 8'd66});
    drain();
    issue8("w8_div_s_m100d7", MODE_DIV, 1'b1, 8'h9C, 8'd7, 16'hFEF2);
    drain();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
